// File: rtl/led_blink_top.sv
// Board top for the 8-LED heartbeat demo.
// LED0 blinks at 50% duty; LED7..LED1 count completed blink periods.
module led_blink_top #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK50MHz,
  input  logic RST_N,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam int CW =
    (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(HALF_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run_en;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   led0_q, led0_d;
  logic [6:0]             per_q, per_d;

  // Reset release is resynchronized; assertion stays asynchronous
  always_ff @(posedge CLK50MHz or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign run_en = sync_q[SYNC_STAGES-1];

  // Prescaler wrap toggles LED0; its falling toggle closes a period
  always_comb begin
    cnt_d  = cnt_q;
    led0_d = led0_q;
    per_d  = per_q;
    if (run_en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        led0_d = ~led0_q;
        if (led0_q) begin
          per_d = per_q + 7'd1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler, heartbeat and period-count registers
  always_ff @(posedge CLK50MHz or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      led0_q <= 1'b0;
      per_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      led0_q <= led0_d;
      per_q  <= per_d;
    end
  end

  assign LED0 = led0_q;
  assign LED1 = per_q[0];
  assign LED2 = per_q[1];
  assign LED3 = per_q[2];
  assign LED4 = per_q[3];
  assign LED5 = per_q[4];
  assign LED6 = per_q[5];
  assign LED7 = per_q[6];

endmodule

// File: tb/tb_led_blink_top.sv
// Bench for led_blink_top: random run/reset
// sequences against an edge-count model.
module tb_led_blink_top;

  localparam int HP   = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a0, a1, a2, a3, a4, a5, a6, a7;
  logic b0, b1, b2, b3, b4, b5, b6, b7;

  int n_vec  = 0;
  int n_miss = 0;
  int e      = 0;

  always #10 clk = ~clk;

  led_blink_top #(.HALF_PERIOD(HP), .SYNC_STAGES(SYNC)) u_dut (
    .CLK50MHz(clk), .RST_N(rst_n),
    .LED0(a0), .LED1(a1), .LED2(a2), .LED3(a3),
    .LED4(a4), .LED5(a5), .LED6(a6), .LED7(a7)
  );

  led_blink_top #(.HALF_PERIOD(1), .SYNC_STAGES(SYNC)) u_dut1 (
    .CLK50MHz(clk), .RST_N(rst_n),
    .LED0(b0), .LED1(b1), .LED2(b2), .LED3(b3),
    .LED4(b4), .LED5(b5), .LED6(b6), .LED7(b7)
  );

  // Clock edges seen with reset released since the last reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  function automatic logic [7:0] model(int edges, int hp);
    int n;
    logic l0;
    logic [6:0] c;
    n  = (edges > SYNC) ? edges - SYNC : 0;
    l0 = ((n / hp) % 2) == 1;
    c  = 7'((n / (2 * hp)) % 128);
    return {c, l0};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b want %b (e=%0d t=%0t)",
               tag, got, exp, e, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/hp4"}, {a7, a6, a5, a4, a3, a2, a1, a0},
        model(e, HP));
    chk({tag, "/hp1"}, {b7, b6, b5, b4, b3, b2, b1, b0},
        model(e, 1));
  endtask

  task automatic run(input int k, input string tag);
    repeat (k) begin
      @(negedge clk);
      chk_all(tag);
    end
  endtask

  // Called at a negedge: async assert mid-cycle, optional hold
  task automatic do_reset(input int hold);
    #3 rst_n = 1'b0;
    #1 chk({"async"}, {a7, a6, a5, a4, a3, a2, a1, a0}, 8'h00);
    chk({"async1"}, {b7, b6, b5, b4, b3, b2, b1, b0}, 8'h00);
    if (hold == 0) begin
      #1 rst_n = 1'b1;
    end else begin
      run(hold, "inrst");
      #3 rst_n = 1'b1;
    end
  endtask

  initial begin
    int step_edge;
    run(5, "reset");
    #3 rst_n = 1'b1;
    run(5, "pre");
    run(3, "first");
    run(1000, "long");
    run(200, "wrap");
    for (int it = 0; it < 40; it++) begin
      run($urandom_range(1, 120), "rand");
      do_reset(($urandom_range(0, 1) == 1)
               ? int'($urandom_range(1, 4)) : 0);
    end
    // mid-period reset with LED0=1, count=5
    do_reset(2);
    step_edge = 2 + 5 * 2 * HP + HP + 1;
    run(step_edge, "tocnt5");
    chk("cnt5", {a7, a6, a5, a4, a3, a2, a1, a0}, 8'h0B);
    do_reset(0);
    run(20, "restart");
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
